uart_rx_assembler: RTL
======================

// Module: uart_rx_assembler
// PURPOSE
//   Sits directly downstream of uart_rx. Collects the received byte stream
//   into a vector of N_NUMS numbers, each NUM_BYTES bytes wide, and presents
//   the completed vector to the uart top level as its rx number array. It
//   raises a one-cycle vector_valid strobe per complete vector. Partial
//   vectors are discarded on explicit resync or on inter-byte timeout.
// PARAMETERS
//   N_NUMS         4      numbers per vector
//   NUM_BYTES      2      bytes per number; NUM_W = 8*NUM_BYTES
//   TIMEOUT_CYCLES 65535  clk cycles allowed between bytes in COLLECT; 0 disables timeout
// PORTS
//   clk                 in   1               system clock
//   reset               in   1               asynchronous, active-high reset
//   byte_valid          in   1               1-cycle strobe from uart_rx (rx_available)
//   byte_data           in   8               received byte, qualified by byte_valid
//   new_vector_incoming in   1               resync: drop any partial vector
//   nums                out  N_NUMS*NUM_W    number k at nums[k*NUM_W +: NUM_W]
//   vector_valid        out  1               1-cycle pulse: nums just updated
//   busy                out  1               high while in COLLECT
//   timeout_err         out  1               1-cycle pulse: partial vector discarded by timeout
// BEHAVIOUR
//   - Reset (async, any time, including mid-vector): state=IDLE, byte count=0,
//     timer=0, staging=0, nums=0, vector_valid=0, busy=0, timeout_err=0.
//   - TOTAL = N_NUMS*NUM_BYTES. Byte order: number 0 arrives first; within a
//     number the first byte is the MSB (big-endian).
//   - Bytes are written into a staging register; nums is a separate output
//     register. nums changes only on commit and holds the last complete vector
//     otherwise. Partial data never reaches nums.
//   - States:
//     IDLE: byte_valid -> store byte at index 0, count=1, timer=0.
//       Go to COLLECT, or commit immediately if TOTAL==1.
//     COLLECT: byte_valid -> store at index count, count+1, timer=0.
//       If the stored byte was index TOTAL-1 -> commit, count=0, go to IDLE.
//       No byte this cycle -> timer+1. If TIMEOUT_CYCLES!=0 and timer reaches
//       TIMEOUT_CYCLES -> discard, count=0, timeout_err=1 for 1 cycle, go to IDLE.
//   - Commit: nums <= staging including the final byte. vector_valid=1 on the
//     clk edge after the final byte_valid (latency 1 cycle). High for exactly 1 cycle.
//   - busy is registered, equal to (state==COLLECT).
//   - new_vector_incoming, any state: count=0, timer=0, state=IDLE; nums unchanged.
//     If byte_valid is asserted in the same cycle, that byte is taken as index 0
//     of a fresh vector (state->COLLECT, count=1). A resync never emits
//     vector_valid or timeout_err.
//   - Back-to-back byte_valid on consecutive cycles is accepted with no loss.
//     A commit cycle followed by byte_valid starts the next vector at index 0.
//   - Timer width is $clog2(TIMEOUT_CYCLES+1) and it saturates, never wraps.
//     Count width is $clog2(TOTAL+1).
//   - byte_valid in IDLE never asserts timeout_err. The timer runs only in COLLECT.
// TESTING
//   1) Defaults. Send 12 34 56 78 9A BC DE F0 with 160-cycle gaps. Expect
//      vector_valid 1 cycle after the 8th strobe, nums[0..3]=1234,5678,9ABC,DEF0,
//      busy high from after byte 1 until commit.
//   2) Send AA BB CC, pulse new_vector_incoming, then send the 8 bytes of test 1.
//      Expect exactly one vector_valid, nums as in test 1, no timeout_err.
//   3) TIMEOUT_CYCLES=100. Send 2 bytes, then idle. Expect timeout_err for 1 cycle
//      100 cycles after the 2nd strobe, busy low after, nums still at the prior vector.
//   4) Send 16 bytes 00..0F on consecutive cycles. Expect two vector_valid pulses
//      8 cycles apart: nums = 0001,0203,0405,0607, then 0809,0A0B,0C0D,0E0F.
//   5) Assert reset after 5 bytes of a vector. Expect nums=0 and all outputs low;
//      a following 8-byte vector commits correctly.
//   6) Send 3 bytes, then assert new_vector_incoming and byte_valid together with 0x55,
//      then 7 more bytes 01..07. Expect nums[0]=5501, and exactly one vector_valid.

Source files
------------

// File: rtl/uart_rx_assembler.sv
// Packs the uart_rx byte stream into a vector of N_NUMS big-endian numbers.
// A vector is published on nums with a one-cycle vector_valid strobe once it is complete.
module uart_rx_assembler #(
  parameter int N_NUMS         = 4,
  parameter int NUM_BYTES      = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            byte_valid,
  input  logic [7:0]                      byte_data,
  input  logic                            new_vector_incoming,
  output logic [N_NUMS*NUM_BYTES*8-1:0]   nums,
  output logic                            vector_valid,
  output logic                            busy,
  output logic                            timeout_err,
  output logic                            dbg_state
);

  localparam int NUM_W = 8 * NUM_BYTES;
  localparam int TOTAL = N_NUMS * NUM_BYTES;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);
  localparam logic [TW-1:0] TMO      = TW'(TIMEOUT_CYCLES);

  // Handshake: byte_valid is a one-cycle strobe with no back-pressure; every
  // strobed byte is consumed in the cycle it is presented.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              count, count_nxt;
  logic [TW-1:0]              timer, timer_nxt;
  logic [7:0]                 staging     [TOTAL];
  logic [7:0]                 staging_nxt [TOTAL];
  logic [N_NUMS*NUM_W-1:0]    nums_nxt;
  logic [N_NUMS*NUM_W-1:0]    staged_vec;
  logic                       vv_nxt;
  logic                       te_nxt;
  logic                       take_first;
  logic [CW-1:0]              idx;

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    timer_nxt   = timer;
    staging_nxt = staging;
    nums_nxt    = nums;
    vv_nxt      = 1'b0;
    te_nxt      = 1'b0;
    staged_vec  = '0;
    // A resync byte is index 0 of a fresh vector, exactly like a byte in IDLE.
    take_first  = new_vector_incoming || (state == IDLE);
    idx         = take_first ? '0 : count;

    if (byte_valid) begin
      staging_nxt[idx[IW-1:0]] = byte_data;
      timer_nxt                = '0;
      if (idx == LAST_IDX) begin
        count_nxt = '0;
        state_nxt = IDLE;
        vv_nxt    = 1'b1;
      end else begin
        count_nxt = idx + CW'(1);
        state_nxt = COLLECT;
      end
    end else if (new_vector_incoming) begin
      count_nxt = '0;
      timer_nxt = '0;
      state_nxt = IDLE;
    end else if (state == COLLECT) begin
      if (timer != '1) begin
        timer_nxt = timer + TW'(1);
      end
      if ((TIMEOUT_CYCLES != 0) && (timer_nxt == TMO)) begin
        count_nxt = '0;
        timer_nxt = '0;
        state_nxt = IDLE;
        te_nxt    = 1'b1;
      end
    end

    // Arrival order is number 0 first, MSB first within each number.
    for (int k = 0; k < N_NUMS; k++) begin
      for (int j = 0; j < NUM_BYTES; j++) begin
        staged_vec[k*NUM_W + (NUM_BYTES-1-j)*8 +: 8] = staging_nxt[k*NUM_BYTES + j];
      end
    end
    if (vv_nxt) begin
      nums_nxt = staged_vec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      timer        <= '0;
      nums         <= '0;
      vector_valid <= 1'b0;
      timeout_err  <= 1'b0;
      for (int i = 0; i < TOTAL; i++) begin
        staging[i] <= '0;
      end
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      timer        <= timer_nxt;
      nums         <= nums_nxt;
      vector_valid <= vv_nxt;
      timeout_err  <= te_nxt;
      staging      <= staging_nxt;
    end
  end

  assign busy      = (state == COLLECT);
  assign dbg_state = state;

endmodule
